instr_sequencer: RTL



---
 rtl/instr_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: owns the instruction register, flag register and T-state
// counter, and packs them into the 9-bit instin word for the control unit.
// Every output is a direct register field; no input reaches an output
// combinationally.
module instr_sequencer #(
    parameter int STEPS = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pmode,
    input  logic [7:0] bus_in,
    input  logic       ir_load,
    input  logic       cf_in,
    input  logic       zf_in,
    input  logic       flag_load,
    input  logic       step_rst,
    input  logic       hlt,
    output logic [8:0] instin,
    output logic [3:0] ir_operand,
    output logic [2:0] step,
    output logic       halted
);

    // Run/halt state. The state is visible to checkers through the halted output.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic       cf_q, cf_d;
    logic       zf_q, zf_d;
    logic [2:0] step_q, step_d;

    // Next-state logic. Priority from highest to lowest:
    // pmode, halted, then (hlt, step_rst, advance).
    // The IR and flag loads act independently of the step update.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cf_d    = cf_q;
        zf_d    = zf_q;
        step_d  = step_q;

        if (pmode) begin
            // Programming mode parks the machine at step 0 with a cleared
            // opcode. The flags hold, and all loads are ignored.
            state_d = ST_RUN;
            step_d  = 3'd0;
            ir_d    = 8'd0;
        end else if (state_q == ST_RUN) begin
            if (ir_load) begin
                ir_d = bus_in;
            end
            if (flag_load) begin
                cf_d = cf_in;
                zf_d = zf_in;
            end
            if (hlt) begin
                // Halt takes priority over step_rst. The step holds.
                state_d = ST_HALT;
            end else if (step_rst) begin
                step_d = 3'd0;
            end else if (step_q == LAST_STEP) begin
                step_d = 3'd0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
        // In ST_HALT with no pmode, every register holds.
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            ir_q    <= 8'd0;
            cf_q    <= 1'b0;
            zf_q    <= 1'b0;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cf_q    <= cf_d;
            zf_q    <= zf_d;
            step_q  <= step_d;
        end
    end

    // Outputs are taken straight from the register fields.
    always_comb begin
        instin     = {ir_q[7:4], cf_q, zf_q, step_q};
        ir_operand = ir_q[3:0];
        step       = step_q;
        halted     = (state_q == ST_HALT);
    end

endmodule
